eth_frame_tx: RTL and testbench

- Parametrised Ethernet MAC transmit framer.
- Accepts a payload byte stream with valid/ready/last handshake.
- Emits a GMII-style byte stream (txd/tx_en/tx_er) toward the SGMII/PCS path, adding the preamble, SFD, minimum-length padding, CRC-32 FCS and inter-frame gap.
- Successor to the fixed 7x55/D5/12x00 frame sender: lengths are configurable, and it adds FCS, padding, underrun abort and a frame counter.

---
 rtl/eth_frame_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_eth_frame_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_tx.sv
// ============================================================================
// Module   : eth_frame_tx
// Purpose  : Ethernet MAC transmit framer. Takes a payload byte stream
//            (valid/ready/last) and emits a GMII-style byte stream with
//            preamble, SFD, zero padding to a minimum payload length,
//            CRC-32 FCS and an inter-frame gap. A payload underrun aborts
//            the frame with a one-cycle tx_er marker.
// Ports    : clock          - 125 MHz byte clock
//            reset_n        - synchronous active-low reset
//            s_data/s_valid/s_last/s_ready - payload stream in
//            txd/tx_en/tx_er - registered transmit byte stream out
//            busy           - high whenever the framer is not idle
//            frames_sent    - completed frames (wraps)
//            frames_aborted - underrun aborts (wraps)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_frame_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
  parameter int MIN_PAYLOAD  = 60,
  parameter int APPEND_FCS   = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       txd,
  output logic             tx_en,
  output logic             tx_er,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent,
  output logic [CNT_W-1:0] frames_aborted
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SFD      = 3'd2,
    S_DATA     = 3'd3,
    S_PAD      = 3'd4,
    S_FCS      = 3'd5,
    S_ABORT    = 3'd6,
    S_IFG      = 3'd7
  } state_t;

  localparam logic [15:0]      c_PRE_LAST  = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0]      c_IFG_LAST  = 16'(IFG_LEN - 1);
  localparam logic [15:0]      c_MIN       = 16'(MIN_PAYLOAD);
  localparam logic [2:0]       c_FCS_BYTES = (APPEND_FCS != 0) ? 3'd4 : 3'd0;
  localparam logic [31:0]      c_POLY      = 32'hEDB88320;
  localparam logic [31:0]      c_CRC_INIT  = 32'hFFFFFFFF;
  localparam logic [CNT_W-1:0] c_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [15:0]      r_tmr;      // preamble / IFG cycle counter
  logic [15:0]      r_count;    // payload + pad bytes, saturating
  logic [2:0]       r_fcs_idx;  // FCS bytes already placed on txd
  logic [31:0]      r_crc;
  logic [7:0]       r_txd;
  logic             r_tx_en;
  logic             r_tx_er;
  logic [CNT_W-1:0] r_sent;
  logic [CNT_W-1:0] r_aborted;

  logic             w_ready;
  logic [15:0]      w_count_inc;
  logic [31:0]      w_crc_data;
  logic [31:0]      w_crc_zero;
  logic [31:0]      w_crc_inv;
  logic [7:0]       w_fcs_byte;

  // One byte of the reflected CRC-32, LSB of the data byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ c_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // The SFD cycle already accepts the first payload byte so that it
  // lands on txd immediately after 0xD5.
  assign w_ready     = (r_state == S_SFD) || (r_state == S_DATA) || (r_state == S_ABORT);
  assign w_count_inc = (r_count == 16'hFFFF) ? r_count : (r_count + 16'd1);
  assign w_crc_data  = crc_byte(r_crc, s_data);
  assign w_crc_zero  = crc_byte(r_crc, 8'h00);
  assign w_crc_inv   = ~r_crc;
  assign w_fcs_byte  = w_crc_inv[{r_fcs_idx[1:0], 3'b000} +: 8];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_count   <= '0;
      r_fcs_idx <= '0;
      r_crc     <= c_CRC_INIT;
      r_txd     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_er   <= 1'b0;
      r_sent    <= '0;
      r_aborted <= '0;
    end else begin
      r_tx_er <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_txd   <= 8'h00;
          r_tx_en <= 1'b0;
          if (s_valid) begin
            r_state   <= S_PREAMBLE;
            r_tmr     <= '0;
            r_count   <= '0;
            r_fcs_idx <= '0;
            r_crc     <= c_CRC_INIT;
            r_txd     <= 8'h55;
            r_tx_en   <= 1'b1;
          end
        end

        S_PREAMBLE: begin
          if (r_tmr == c_PRE_LAST) begin
            r_state <= S_SFD;
            r_txd   <= 8'hD5;
          end else begin
            r_tmr <= r_tmr + 16'd1;
            r_txd <= 8'h55;
          end
        end

        S_SFD, S_DATA: begin
          if (s_valid) begin
            r_txd   <= s_data;
            r_crc   <= w_crc_data;
            r_count <= w_count_inc;
            if (s_last) begin
              // The last byte is still shown on txd during PAD/FCS entry.
              r_state <= (w_count_inc < c_MIN) ? S_PAD : S_FCS;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            // Underrun: one marker byte, then swallow the rest of the frame.
            r_txd     <= 8'h00;
            r_tx_en   <= 1'b1;
            r_tx_er   <= 1'b1;
            r_aborted <= r_aborted + c_ONE;
            r_state   <= S_ABORT;
          end
        end

        S_PAD: begin
          if (r_count < c_MIN) begin
            r_txd   <= 8'h00;
            r_crc   <= w_crc_zero;
            r_count <= w_count_inc;
          end else if (c_FCS_BYTES != 3'd0) begin
            r_txd     <= w_fcs_byte;
            r_fcs_idx <= r_fcs_idx + 3'd1;
            r_state   <= S_FCS;
          end else begin
            r_state <= S_IFG;
            r_tmr   <= '0;
            r_txd   <= 8'h00;
            r_tx_en <= 1'b0;
            r_sent  <= r_sent + c_ONE;
          end
        end

        S_FCS: begin
          if (r_fcs_idx < c_FCS_BYTES) begin
            r_txd     <= w_fcs_byte;
            r_fcs_idx <= r_fcs_idx + 3'd1;
          end else begin
            r_state <= S_IFG;
            r_tmr   <= '0;
            r_txd   <= 8'h00;
            r_tx_en <= 1'b0;
            r_sent  <= r_sent + c_ONE;
          end
        end

        S_ABORT: begin
          r_txd   <= 8'h00;
          r_tx_en <= 1'b0;
          if (s_valid && s_last) begin
            r_state <= S_IFG;
            r_tmr   <= '0;
          end
        end

        S_IFG: begin
          r_txd   <= 8'h00;
          r_tx_en <= 1'b0;
          if (r_tmr == c_IFG_LAST) begin
            // Starting straight from the last gap cycle keeps the gap
            // at exactly IFG_LEN idle bytes for back-to-back frames.
            if (s_valid) begin
              r_state   <= S_PREAMBLE;
              r_tmr     <= '0;
              r_count   <= '0;
              r_fcs_idx <= '0;
              r_crc     <= c_CRC_INIT;
              r_txd     <= 8'h55;
              r_tx_en   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_tmr <= r_tmr + 16'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready        = w_ready;
  assign txd            = r_txd;
  assign tx_en          = r_tx_en;
  assign tx_er          = r_tx_er;
  assign busy           = (r_state != S_IDLE);
  assign frames_sent    = r_sent;
  assign frames_aborted = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_eth_frame_tx.sv
// ============================================================================
// Module   : tb_eth_frame_tx
// Purpose  : Self-checking bench for eth_frame_tx. Three framer instances
//            with different parameter sets are driven from cycle-accurate
//            schedules. Each schedule (inputs and expected outputs per
//            cycle) is built from frame-level rules: preamble, SFD, data,
//            zero pad, table-driven CRC-32, gap, underrun and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_frame_tx;

  localparam int NCFG = 3;
  localparam int NC   = 6000;

  logic clock = 1'b0;
  always #4 clock = ~clock;

  logic [NCFG-1:0] rstn = '0;
  logic [NCFG-1:0] sv   = '0;
  logic [NCFG-1:0] sl   = '0;
  logic [7:0]      sd   [NCFG];
  logic [NCFG-1:0] rdy, en, er, bsy;
  logic [7:0]      txd  [NCFG];
  logic [15:0]     fs   [NCFG];
  logic [15:0]     fa   [NCFG];

  // cfg0: defaults; cfg1: no padding; cfg2: short preamble/gap, no FCS
  eth_frame_tx #(.PREAMBLE_LEN(7), .IFG_LEN(12), .MIN_PAYLOAD(60), .APPEND_FCS(1), .CNT_W(16)) u_dut0 (
    .clock(clock), .reset_n(rstn[0]), .s_data(sd[0]), .s_valid(sv[0]), .s_last(sl[0]),
    .s_ready(rdy[0]), .txd(txd[0]), .tx_en(en[0]), .tx_er(er[0]), .busy(bsy[0]),
    .frames_sent(fs[0]), .frames_aborted(fa[0]));
  eth_frame_tx #(.PREAMBLE_LEN(7), .IFG_LEN(12), .MIN_PAYLOAD(0), .APPEND_FCS(1), .CNT_W(16)) u_dut1 (
    .clock(clock), .reset_n(rstn[1]), .s_data(sd[1]), .s_valid(sv[1]), .s_last(sl[1]),
    .s_ready(rdy[1]), .txd(txd[1]), .tx_en(en[1]), .tx_er(er[1]), .busy(bsy[1]),
    .frames_sent(fs[1]), .frames_aborted(fa[1]));
  eth_frame_tx #(.PREAMBLE_LEN(3), .IFG_LEN(1), .MIN_PAYLOAD(0), .APPEND_FCS(0), .CNT_W(16)) u_dut2 (
    .clock(clock), .reset_n(rstn[2]), .s_data(sd[2]), .s_valid(sv[2]), .s_last(sl[2]),
    .s_ready(rdy[2]), .txd(txd[2]), .tx_en(en[2]), .tx_er(er[2]), .busy(bsy[2]),
    .frames_sent(fs[2]), .frames_aborted(fa[2]));

  function automatic int cfg_pl(input int g);  return (g == 2) ? 3 : 7;   endfunction
  function automatic int cfg_ifg(input int g); return (g == 2) ? 1 : 12;  endfunction
  function automatic int cfg_min(input int g); return (g == 0) ? 60 : 0;  endfunction
  function automatic int cfg_nf(input int g);  return (g == 2) ? 0 : 4;   endfunction

  // Per-cycle schedule: q_* are inputs, x_* expected outputs.
  bit        q_rst [NCFG][NC];
  bit        q_v   [NCFG][NC];
  bit        q_l   [NCFG][NC];
  bit [7:0]  q_d   [NCFG][NC];
  bit        x_en  [NCFG][NC];
  bit        x_er  [NCFG][NC];
  bit [7:0]  x_d   [NCFG][NC];
  bit        x_rdy [NCFG][NC];
  bit        x_bsy [NCFG][NC];
  bit        x_clr [NCFG][NC];
  int        x_is  [NCFG][NC];
  int        x_ia  [NCFG][NC];
  bit [15:0] x_fs  [NCFG][NC];
  bit [15:0] x_fa  [NCFG][NC];
  bit [7:0]  act_d [NCFG][NC];
  bit        act_e [NCFG][NC];

  int avail [NCFG];
  int vfree [NCFG];
  int ncyc  [NCFG];
  int mark_t   [NCFG];   // start cycle of the first frame
  int mark_fcs [NCFG];   // first FCS cycle of the first normal frame

  bit [7:0]    pay [256];
  logic [31:0] tbl [256];

  int checks = 0;
  int errors = 0;

  task automatic chk(input int g, input int c, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL cfg%0d cycle %0d %s: got 0x%0h expected 0x%0h", g, c, nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fcs_model(input int n, input int p);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n + p; i++) begin
      b = (i < n) ? pay[i] : 8'h00;
      c = tbl[c[7:0] ^ b] ^ (c >> 8);
    end
    return ~c;
  endfunction

  task automatic put_in(input int g, input int c, input bit [7:0] d, input bit l);
    if (c < NC) begin q_v[g][c] = 1'b1; q_d[g][c] = d; q_l[g][c] = l; end
  endtask

  task automatic put_out(input int g, input int c, input bit e, input bit r, input bit [7:0] d);
    if (c < NC) begin x_en[g][c] = e; x_er[g][c] = r; x_d[g][c] = d; end
  endtask

  task automatic set_rng(input int g, input int lo, input int hi, input bit is_rdy);
    for (int c = lo; c <= hi && c < NC; c++) begin
      if (is_rdy) x_rdy[g][c] = 1'b1; else x_bsy[g][c] = 1'b1;
    end
  endtask

  // Appends one frame (payload pay[0..n-1]) to schedule g.
  // kab>0: underrun after kab bytes, rest resumes dab cycles later.
  // rat>=0: reset asserted while payload byte rat is on txd.
  task automatic add_frame(input int g, input int n, input int kab, input int dab, input int rat, input int gap);
    int pl, ifg, mn, nf, v, t, s, p, e, a, r;
    logic [31:0] f;
    pl = cfg_pl(g); ifg = cfg_ifg(g); mn = cfg_min(g); nf = cfg_nf(g);
    v = vfree[g] + gap;
    t = (v > avail[g]) ? v : avail[g];
    s = t + pl + 1;
    if (mark_t[g] < 0) mark_t[g] = t;
    for (int c = v; c <= s; c++) put_in(g, c, pay[0], n == 1);
    for (int i = 1; i <= pl; i++) put_out(g, t + i, 1'b1, 1'b0, 8'h55);
    put_out(g, s, 1'b1, 1'b0, 8'hD5);
    if (rat >= 0) begin
      r = s + rat + 1;
      for (int i = 1; i <= rat + 1; i++) put_in(g, s + i, pay[i], i == n - 1);
      for (int i = 0; i <= rat; i++) put_out(g, s + i + 1, 1'b1, 1'b0, pay[i]);
      set_rng(g, s, r, 1'b1);
      set_rng(g, t + 1, r, 1'b0);
      for (int c = r; c <= r + 2; c++) q_rst[g][c] = 1'b1;
      x_clr[g][r + 1] = 1'b1;
      avail[g] = r + 3;
      vfree[g] = r + 3;
    end else if (kab > 0) begin
      for (int i = 1; i < kab; i++) put_in(g, s + i, pay[i], 1'b0);
      for (int i = 0; i < kab; i++) put_out(g, s + i + 1, 1'b1, 1'b0, pay[i]);
      put_out(g, s + kab + 1, 1'b1, 1'b1, 8'h00);
      x_ia[g][s + kab + 1]++;
      for (int i = kab; i < n; i++) put_in(g, s + dab + i, pay[i], i == n - 1);
      a = s + dab + n - 1;
      set_rng(g, s, a, 1'b1);
      set_rng(g, t + 1, a + ifg, 1'b0);
      avail[g] = a + ifg;
      vfree[g] = a + 1;
    end else begin
      for (int i = 1; i < n; i++) put_in(g, s + i, pay[i], i == n - 1);
      for (int i = 0; i < n; i++) put_out(g, s + i + 1, 1'b1, 1'b0, pay[i]);
      p = (mn > n) ? (mn - n) : 0;
      for (int i = 1; i <= p; i++) put_out(g, s + n + i, 1'b1, 1'b0, 8'h00);
      f = fcs_model(n, p);
      for (int i = 0; i < nf; i++) put_out(g, s + n + p + 1 + i, 1'b1, 1'b0, f[8*i +: 8]);
      e = s + n + p + nf;
      if (mark_fcs[g] < 0) mark_fcs[g] = s + n + p + 1;
      x_is[g][e + 1]++;
      set_rng(g, s, s + n - 1, 1'b1);
      set_rng(g, t + 1, e + ifg, 1'b0);
      avail[g] = e + ifg;
      vfree[g] = s + n;
    end
  endtask

  task automatic rand_frame(input int g, input int maxn);
    int n, k;
    n = $urandom_range(1, maxn);
    for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
    if (n >= 2 && $urandom_range(0, 3) == 0) begin
      k = $urandom_range(1, n - 1);
      add_frame(g, n, k, $urandom_range(1, 3), -1, $urandom_range(0, 3));
    end else begin
      add_frame(g, n, 0, 0, -1, $urandom_range(0, 3));
    end
  endtask

  task automatic run_cfg(input int g);
    for (int c = 0; c < ncyc[g]; c++) begin
      @(posedge clock);
      #1;
      rstn[g] = ~q_rst[g][c];
      sv[g]   = q_v[g][c];
      sl[g]   = q_l[g][c];
      sd[g]   = q_d[g][c];
      @(negedge clock);
      act_d[g][c] = txd[g];
      act_e[g][c] = en[g];
      if (c >= 1) begin
        chk(g, c, "txd",            txd[g],  x_d[g][c]);
        chk(g, c, "tx_en",          en[g],   x_en[g][c]);
        chk(g, c, "tx_er",          er[g],   x_er[g][c]);
        chk(g, c, "s_ready",        rdy[g],  x_rdy[g][c]);
        chk(g, c, "busy",           bsy[g],  x_bsy[g][c]);
        chk(g, c, "frames_sent",    fs[g],   x_fs[g][c]);
        chk(g, c, "frames_aborted", fa[g],   x_fa[g][c]);
      end
    end
  endtask

  initial begin
    logic [31:0] lit;
    logic [31:0] rr;
    int cs, ca, run;

    for (int g = 0; g < NCFG; g++) sd[g] = 8'h00;

    for (int i = 0; i < 256; i++) begin
      rr = 32'(i);
      for (int b = 0; b < 8; b++) rr = rr[0] ? ((rr >> 1) ^ 32'hEDB88320) : (rr >> 1);
      tbl[i] = rr;
    end

    // Pin the CRC model to the well-known check value of "123456789".
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    chk(-1, 0, "crc_model_check_value", fcs_model(9, 0), 32'hCBF43926);

    for (int g = 0; g < NCFG; g++) begin
      for (int c = 0; c <= 3; c++) q_rst[g][c] = 1'b1;
      avail[g] = 4; vfree[g] = 4; mark_t[g] = -1; mark_fcs[g] = -1;
    end

    // cfg0: 10-byte padded frame, two 64-byte back-to-back frames,
    // 20-byte underrun after 5 bytes, reset mid-payload, random frames.
    for (int i = 0; i < 10; i++) pay[i] = 8'(i + 1);
    add_frame(0, 10, 0, 0, -1, 3);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      add_frame(0, 64, 0, 0, -1, 0);
    end
    for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
    add_frame(0, 20, 5, 2, -1, 0);
    for (int i = 0; i < 15; i++) pay[i] = 8'($urandom);
    add_frame(0, 15, 0, 0, -1, 0);
    for (int i = 0; i < 40; i++) pay[i] = 8'($urandom);
    add_frame(0, 40, 0, 0, 30, 1);
    for (int i = 0; i < 12; i++) pay[i] = 8'($urandom);
    add_frame(0, 12, 0, 0, -1, 0);
    for (int f = 0; f < 6; f++) rand_frame(0, 80);

    // cfg1: "123456789" with FCS and no padding, one-byte frame, random.
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    add_frame(1, 9, 0, 0, -1, 0);
    pay[0] = 8'hA5;
    add_frame(1, 1, 0, 0, -1, 0);
    for (int f = 0; f < 6; f++) rand_frame(1, 40);

    // cfg2: 3-byte preamble, one-cycle gap, no FCS.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
      add_frame(2, 8, 0, 0, -1, 0);
    end
    pay[0] = 8'h3C;
    add_frame(2, 1, 0, 0, -1, 0);
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
    add_frame(2, 6, 1, 1, -1, 0);
    for (int f = 0; f < 6; f++) rand_frame(2, 20);

    for (int g = 0; g < NCFG; g++) begin
      ncyc[g] = ((avail[g] > vfree[g]) ? avail[g] : vfree[g]) + 5;
      if (ncyc[g] > NC) ncyc[g] = NC;
      cs = 0; ca = 0;
      for (int c = 0; c < NC; c++) begin
        if (x_clr[g][c]) begin cs = 0; ca = 0; end
        cs += x_is[g][c];
        ca += x_ia[g][c];
        x_fs[g][c] = 16'(cs);
        x_fa[g][c] = 16'(ca);
      end
    end

    fork
      run_cfg(0);
      run_cfg(1);
      run_cfg(2);
    join

    // Hand-derived expectations for specific frames.
    lit = 32'hCBF43926;
    for (int i = 0; i < 4; i++)
      chk(1, mark_fcs[1] + i, "fcs_123456789", act_d[1][mark_fcs[1] + i], lit[8*i +: 8]);
    run = 0;
    for (int c = mark_t[1] + 1; c < NC && act_e[1][c]; c++) run++;
    chk(1, mark_t[1], "tx_en_len_123456789", run, 21);
    run = 0;
    for (int c = mark_t[0] + 1; c < NC && act_e[0][c]; c++) run++;
    chk(0, mark_t[0], "tx_en_len_10B_padded", run, 72);
    lit = 32'hD5555555;
    for (int i = 0; i < 4; i++)
      chk(2, mark_t[2] + 1 + i, "short_preamble", act_d[2][mark_t[2] + 1 + i], lit[8*i +: 8]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
